instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter RESET_PC SHALL default to 32'h0000_0000 and set the PC loaded on reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pc_src  input  2  next-PC select: 00 = pc+4, 01 = branch, 10 = jal, 11 = jalr.
REQ-006 branch_taken  input  1  branch condition result; sampled only when pc_src=01.
REQ-007 branch_target  input  32  pc+imm_b, computed in the datapath.
REQ-008 jal_target  input  32  pc+imm_j.
REQ-009 jalr_target  input  32  rs1+imm_i; bit 0 is cleared internally.
REQ-010 advance  input  1  the core has retired the current instruction.
REQ-011 imem_req  output  1  instruction memory read request.
REQ-012 imem_addr  output  32  instruction memory word address; equals pc.
REQ-013 imem_ready  input  1  imem_rdata is valid this cycle.
REQ-014 imem_rdata  input  32  instruction word from memory.
REQ-015 instr  output  32  latched instruction.
REQ-016 instr_valid  output  1  instr is valid and held.
REQ-017 opcode  output  7  instr[6:0]; feeds the control unit.
REQ-018 pc, pc_plus4  output  32  current PC and PC+4, the latter for JAL/JALR write-back.
REQ-019 fetch_fault  output  1  misaligned-target trap flag.

Function
REQ-020 The FSM SHALL have four states: IDLE, FETCH, HOLD and FAULT.
REQ-021 IDLE SHALL hold imem_req=0 and SHALL go to FETCH on the next clock.
REQ-022 FETCH SHALL hold imem_req=1 and go to HOLD at the edge where imem_ready=1; instr then loads imem_rdata.
REQ-023 instr_valid SHALL be 1 exactly in HOLD, starting the cycle after imem_ready (1-cycle latency), and imem_req SHALL be 0 in HOLD.
REQ-024 In HOLD with advance=1, pc SHALL load next_pc at the edge and the state SHALL become FETCH (or FAULT, per REQ-027).
REQ-025 advance outside HOLD SHALL be ignored, and imem_ready outside FETCH SHALL be ignored.
REQ-026 next_pc SHALL be selected as follows; all arithmetic is 32-bit and wraps modulo 2^32, so 32'hFFFF_FFFC+4 = 0.
- 00: pc+4.
- 01: branch_target if branch_taken, otherwise pc+4.
- 10: jal_target.
- 11: jalr_target & ~1.
REQ-027 With IFU_MISALIGN_TRAP_EN, a next_pc with bits [1:0] != 00 SHALL enter FAULT with fetch_fault=1, imem_req=0 and instr_valid=0, and pc SHALL hold the faulting instruction's PC; FAULT SHALL be left only by reset.
REQ-028 opcode SHALL always equal instr[6:0], and instr SHALL hold its last value in FETCH.
REQ-029 pc_plus4 SHALL be combinational pc+4.

Reset
REQ-030 On rst assertion the block SHALL, asynchronously:
- set the state to IDLE;
- set pc and imem_addr to RESET_PC;
- set instr to 32'h0000_0013 (NOP), so opcode reads 7'd19;
- clear instr_valid, imem_req and fetch_fault.
REQ-031 Reset during a pending FETCH SHALL abandon the request; an imem_ready arriving after reset SHALL be ignored until FETCH is re-entered.

Configuration
REQ-032 The macro IFU_MISALIGN_TRAP_EN SHALL select misaligned-target handling.
- Defined: REQ-027 applies.
- Undefined: next_pc[1:0] SHALL be forced to 00, the FAULT state SHALL be absent, and fetch_fault SHALL be tied to 0.

Structure
REQ-033 Package rv32i_pkg SHALL hold:
- the pc_src encodings (PC_PLUS4, PC_BRANCH, PC_JAL, PC_JALR);
- the FSM state enum;
- the NOP constant 32'h0000_0013;
- the default reset PC.
REQ-034 The combinational next-PC selection SHALL be the sub-module next_pc_sel; all other logic SHALL stay in instr_fetch_unit.

Verification
REQ-035 Reset then single fetch: release rst, imem_ready=1 in the 2nd cycle with rdata 32'h00500093 -> imem_addr=0, instr_valid=1 next cycle, opcode=7'd19, pc_plus4=4.
REQ-036 Sequential plus stall: pc_src=00, advance=1, memory ready after a 3-cycle wait -> pc=4, imem_req held for 3 cycles, instr_valid=0 until ready+1.
REQ-037 Branch: pc=8, pc_src=01, branch_target=32'h40, branch_taken=1 -> next imem_addr=32'h40; with branch_taken=0 -> 32'hC.
REQ-038 Jumps: pc_src=10 with jal_target=32'h100 -> pc=32'h100; pc_src=11 with jalr_target=32'h205 -> pc=32'h204.
REQ-039 Misalignment with the macro defined: jal_target=32'h102 -> fetch_fault=1, imem_req=0, pc unchanged, until rst. With the macro undefined -> pc=32'h100, fetch_fault=0.
REQ-040 Wrap and mid-fetch reset:
- pc=32'hFFFF_FFFC with pc_src=00 -> pc=0.
- rst asserted while in FETCH -> imem_req drops immediately and pc=RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: next-PC select codes, fetch FSM states, NOP word and default reset PC.
// The FAULT state exists only when IFU_MISALIGN_TRAP_EN is defined.
package rv32i_pkg;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JAL    = 2'b10,
        PC_JALR   = 2'b11
    } pc_src_e;

`ifdef IFU_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10,
        FAULT = 2'b11
    } ifu_state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } ifu_state_e;
`endif

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and the memory (slave).
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Combinational next-PC selection. Without IFU_MISALIGN_TRAP_EN the result is forced word-aligned;
// with it the raw target is passed on so the fetch unit can trap on misalignment.
module next_pc_sel
    import rv32i_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] jal_target,
    input  logic [31:0] jalr_target,
    output logic [31:0] next_pc
);

    logic [31:0] raw_pc;

    always_comb begin
        raw_pc = pc + 32'd4;
        case (pc_src_e'(pc_src))
            PC_PLUS4:  raw_pc = pc + 32'd4;
            PC_BRANCH: raw_pc = branch_taken ? branch_target : (pc + 32'd4);
            PC_JAL:    raw_pc = jal_target;
            PC_JALR:   raw_pc = jalr_target & ~32'd1;
            default:   raw_pc = pc + 32'd4;
        endcase
    end

`ifdef IFU_MISALIGN_TRAP_EN
    assign next_pc = raw_pc;
`else
    assign next_pc = raw_pc & ~32'd3;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch unit: IDLE -> FETCH -> HOLD loop with next-PC selection on advance.
// Optional misaligned-target trap (FAULT state, sticky until reset) under IFU_MISALIGN_TRAP_EN.
module instr_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 pc_src,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_target,
    input  logic [31:0]                jal_target,
    input  logic [31:0]                jalr_target,
    input  logic                       advance,
    instr_fetch_unit_if.master         imem,
    output logic [31:0]                instr,
    output logic                       instr_valid,
    output logic [6:0]                 opcode,
    output logic [31:0]                pc,
    output logic [31:0]                pc_plus4,
    output logic                       fetch_fault
);

    ifu_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_pc;

    next_pc_sel u_next_pc_sel (
        .pc            (pc_q),
        .pc_src        (pc_src),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jal_target    (jal_target),
        .jalr_target   (jalr_target),
        .next_pc       (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem.imem_ready) begin
                    state_d = HOLD;
                    instr_d = imem.imem_rdata;
                end
            end
            HOLD: begin
                if (advance) begin
`ifdef IFU_MISALIGN_TRAP_EN
                    // pc keeps the faulting instruction's address for the trap handler
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
`else
                    pc_d    = next_pc;
                    state_d = FETCH;
`endif
                end
            end
`ifdef IFU_MISALIGN_TRAP_EN
            FAULT: state_d = FAULT;
`endif
            default: state_d = IDLE;
        endcase
    end

    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = (state_q == HOLD);
    assign opcode         = instr_q[6:0];
    assign pc             = pc_q;
    assign pc_plus4       = pc_q + 32'd4;

`ifdef IFU_MISALIGN_TRAP_EN
    assign fetch_fault = (state_q == FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: random memory latency and control flow against a reference PC model.
// Works in both builds (IFU_MISALIGN_TRAP_EN defined or not).
module tb_instr_fetch_unit;
    import rv32i_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] branch_target, jal_target, jalr_target;
    logic        advance;
    logic [31:0] instr, pc, pc_plus4;
    logic        instr_valid, fetch_fault;
    logic [6:0]  opcode;

    instr_fetch_unit_if imem_bus ();

    instr_fetch_unit #(.RESET_PC(RST_PC)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .pc_src        (pc_src),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jal_target    (jal_target),
        .jalr_target   (jalr_target),
        .advance       (advance),
        .imem          (imem_bus),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .opcode        (opcode),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    fetch_t      exp_q[$];
    fetch_t      cur;
    bit          in_hold;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] model_pc;
    bit          mem_stall = 1'b0;
    bit          mon_en = 1'b0;
    bit          first_fetch = 1'b1;
    int unsigned mem_wait = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference next-PC rule, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [1:0] src,
                                             input logic tk, input logic [31:0] bt,
                                             input logic [31:0] jt, input logic [31:0] jrt);
        logic [31:0] n;
        case (src)
            2'd0:    n = cur_pc + 32'd4;
            2'd1:    n = tk ? bt : cur_pc + 32'd4;
            2'd2:    n = jt;
            default: n = jrt - (jrt % 2);
        endcase
`ifndef IFU_MISALIGN_TRAP_EN
        n = n - (n % 4);
`endif
        return n;
    endfunction

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom & ~32'd3;
        if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
        return t;
    endfunction

    // Memory model: random latency on requests, stray ready pulses when nothing is requested.
    initial begin
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_bus.imem_ready = 1'b0;
            imem_bus.imem_rdata = $urandom;
            if (rst) begin
                mem_wait = $urandom_range(0, 3);
            end else if (imem_bus.imem_req) begin
                if (!mem_stall) begin
                    if (mem_wait == 0) begin
                        if (first_fetch) imem_bus.imem_rdata = 32'h0050_0093;
                        first_fetch = 1'b0;
                        chk("imem_addr", imem_bus.imem_addr, model_pc);
                        imem_bus.imem_ready = 1'b1;
                        exp_q.push_back('{pc: model_pc, instr: imem_bus.imem_rdata});
                        mem_wait = $urandom_range(0, 3);
                    end else begin
                        mem_wait--;
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                imem_bus.imem_ready = 1'b1;
            end
        end
    end

    // Monitor: pop one expectation per entry into HOLD, then check it is held steady.
    initial begin
        cur     = '{pc: RST_PC, instr: NOP_INSTR};
        in_hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cur     = '{pc: RST_PC, instr: NOP_INSTR};
                in_hold = 1'b0;
            end else if (mon_en) begin
                if (instr_valid) begin
                    if (!in_hold) begin
                        if (exp_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL hold_without_fetch: got instr_valid=1 expected 0 at %0t", $time);
                        end else begin
                            cur = exp_q.pop_front();
                        end
                        in_hold = 1'b1;
                    end
                    chk("instr", instr, cur.instr);
                    chk("pc", pc, cur.pc);
                    chk("opcode", 32'(opcode), 32'(cur.instr[6:0]));
                    chk("pc_plus4", pc_plus4, cur.pc + 32'd4);
                    chk("req_in_hold", 32'(imem_bus.imem_req), 32'd0);
                end else begin
                    in_hold = 1'b0;
                    chk("instr_kept", instr, cur.instr);
                end
            end
        end
    end

    task automatic wait_hold(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (instr_valid) begin
                advance = 1'b0;
                ok = 1'b1;
                return;
            end
            advance       = 1'($urandom_range(0, 1));
            pc_src        = 2'($urandom_range(0, 3));
            branch_taken  = 1'($urandom_range(0, 1));
            branch_target = $urandom;
            jal_target    = $urandom;
            jalr_target   = $urandom;
        end
        n_vec++;
        n_err++;
        $display("FAIL hold_timeout: got instr_valid=0 expected 1 within 60 cycles");
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        model_pc = RST_PC;
        exp_q.delete();
        rst = 1'b0;
    endtask

    initial begin
        bit          ok;
        logic [1:0]  src;
        logic        tk;
        logic [31:0] bt, jt, jrt, nxt;

        rst = 1'b1; advance = 1'b0; pc_src = '0; branch_taken = 1'b0;
        branch_target = '0; jal_target = '0; jalr_target = '0;
        model_pc = RST_PC;
        repeat (2) @(negedge clk);

        chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_opcode", 32'(opcode), 32'd19);
        chk("rst_pc", pc, RST_PC);
        chk("rst_addr", imem_bus.imem_addr, RST_PC);
        chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
        chk("rst_fault", 32'(fetch_fault), 32'd0);

        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("idle_to_fetch", 32'(imem_bus.imem_req), 32'd1);

        for (int i = 0; i < 200; i++) begin
            wait_hold(ok);
            if (!ok) break;
            src = 2'($urandom_range(0, 3));
            tk  = 1'($urandom_range(0, 1));
            bt  = rand_target();
            jt  = rand_target();
            jrt = ($urandom & ~32'd3) | 32'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) jrt = jrt | 32'd2;
            case (i)
                0, 1: src = 2'd0;
                2: begin src = 2'd1; tk = 1'b1; bt = 32'h40; end
                3: begin src = 2'd1; tk = 1'b0; bt = 32'h80; end
                4: begin src = 2'd2; jt = 32'h100; end
                5: begin src = 2'd3; jrt = 32'h205; end
                6: begin src = 2'd2; jt = 32'hFFFF_FFFC; end
                7: src = 2'd0;
                8: begin src = 2'd2; jt = 32'h102; end
                default: ;
            endcase
            pc_src = src; branch_taken = tk;
            branch_target = bt; jal_target = jt; jalr_target = jrt;
            advance = 1'b1;
            nxt = ref_next(model_pc, src, tk, bt, jt, jrt);
            if (nxt[1:0] == 2'b00) model_pc = nxt;
            @(negedge clk);
            advance = 1'b0;
            if (nxt[1:0] != 2'b00) begin
                repeat (3) begin
                    chk("fault_flag", 32'(fetch_fault), 32'd1);
                    chk("fault_req", 32'(imem_bus.imem_req), 32'd0);
                    chk("fault_valid", 32'(instr_valid), 32'd0);
                    chk("fault_pc", pc, model_pc);
                    @(negedge clk);
                end
                pulse_reset();
            end else begin
                chk("no_fault", 32'(fetch_fault), 32'd0);
            end
        end

        // Reset while a fetch is outstanding must drop the request at once.
        wait_hold(ok);
        mem_stall = 1'b1;
        pc_src    = 2'd0;
        advance   = 1'b1;
        model_pc  = ref_next(model_pc, 2'd0, 1'b0, '0, '0, '0);
        @(negedge clk);
        advance = 1'b0;
        chk("midfetch_req", 32'(imem_bus.imem_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midfetch_req_drop", 32'(imem_bus.imem_req), 32'd0);
        chk("midfetch_pc", pc, RST_PC);
        chk("midfetch_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        model_pc = RST_PC;
        exp_q.delete();
        rst = 1'b0;
        mem_stall = 1'b0;
        wait_hold(ok);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
